// File: rtl/vec_check_pkg.sv
// Shared constants and FSM state encoding for the vector checker sequencer.
package vec_check_pkg;

    localparam int              DEF_DATA_W    = 64;
    localparam int              DEF_DEPTH     = 20;
    localparam int              DEF_KEY_W     = 256;
    localparam int              DEF_TMO_CYC   = 1024;
    localparam logic [255:0]    DEF_KEY_VALUE = 256'h0;

    // One-hot so each state decode is a single flop bit.
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_FETCH = 6'b000010,
        S_LOAD  = 6'b000100,
        S_START = 6'b001000,
        S_WAIT  = 6'b010000,
        S_FIN   = 6'b100000
    } state_e;

endpackage

// File: rtl/vc_timeout_ctr.sv
// Watchdog for one DUT transaction: counts enabled cycles, flags the last allowed one.
module vc_timeout_ctr #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // expired marks the TMO_CYC-th enabled cycle after a clear
    assign expired = enable && (cnt_q == LAST);

    // count enabled cycles, parking at the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + TW'(1);
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vec_check_seq.sv
// Steps a DUT through a ROM of test vectors and counts result mismatches.
module vec_check_seq
    import vec_check_pkg::*;
#(
    parameter int              DATA_W    = DEF_DATA_W,
    parameter int              DEPTH     = DEF_DEPTH,
    parameter int              AW        = $clog2(DEPTH),
    parameter int              CW        = $clog2(DEPTH + 1),
    parameter int              KEY_W     = DEF_KEY_W,
    parameter logic [KEY_W-1:0] KEY_VALUE = KEY_W'(DEF_KEY_VALUE),
    parameter int              TMO_CYC   = DEF_TMO_CYC
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    output logic [CW-1:0]     ap_return,
    input  logic [CW-1:0]     num_vec,
    input  logic              stop_on_err,
    input  logic [KEY_W-1:0]  working_key,
    output logic [AW-1:0]     rom_addr,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_q,
    input  logic [DATA_W-1:0] z_q,
    output logic              dut_start,
    input  logic              dut_ready,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    input  logic              dut_done,
    input  logic [DATA_W-1:0] dut_result,
    output logic [AW-1:0]     first_err_idx,
    output logic              err_seen,
    output logic              tmo_seen
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic [CW-1:0]       n_q, n_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       ret_q, ret_d;
    logic                stop_q, stop_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [AW-1:0]       ferr_q, ferr_d;
    logic [DATA_W-1:0]   dut_a_q, dut_a_d;
    logic [DATA_W-1:0]   dut_b_q, dut_b_d;
    logic [DATA_W-1:0]   exp_q, exp_d;

    logic                key_ok;
    logic                mismatch;
    logic                tmo_clr;
    logic                tmo_en;
    logic                tmo_exp;

    // With the wrong key the sense of the compare is inverted, so a correct DUT fails every vector.
    assign key_ok = (working_key == KEY_VALUE);

    vc_timeout_ctr #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .clear   (tmo_clr),
        .enable  (tmo_en),
        .expired (tmo_exp)
    );

    assign rom_addr      = AW'(idx_q);
    assign ap_ready      = ap_done;
    assign ap_idle       = (state_q == S_IDLE) && !ap_start;
    assign ap_return     = ret_q;
    assign first_err_idx = ferr_q;
    assign err_seen      = err_q;
    assign tmo_seen      = tmo_q;
    assign dut_a         = dut_a_q;
    assign dut_b         = dut_b_q;

    // next-state, datapath updates and per-state strobes
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ret_d     = ret_q;
        stop_d    = stop_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        ferr_d    = ferr_q;
        dut_a_d   = dut_a_q;
        dut_b_d   = dut_b_q;
        exp_d     = exp_q;
        rom_ce    = 1'b0;
        dut_start = 1'b0;
        ap_done   = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        mismatch  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    n_d     = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
                    stop_d  = stop_on_err;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    ferr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (idx_q == n_q) begin
                    // result is loaded on the way into FIN so it is valid alongside ap_done
                    ret_d   = cnt_q;
                    state_d = S_FIN;
                end else begin
                    rom_ce  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dut_a_d = a_q;
                dut_b_d = b_q;
                exp_d   = z_q;
                state_d = S_START;
            end
            S_START: begin
                dut_start = 1'b1;
                tmo_clr   = 1'b1;
                if (dut_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_en = 1'b1;
                if (dut_done || tmo_exp) begin
                    // a result arriving on the final allowed cycle beats the timeout
                    if (dut_done)
                        mismatch = key_ok ? (dut_result != exp_q) : (dut_result == exp_q);
                    else begin
                        mismatch = 1'b1;
                        tmo_d    = 1'b1;
                    end
                    if (mismatch) begin
                        if (cnt_q != CNT_MAX)
                            cnt_d = cnt_q + CW'(1);
                        if (!err_q) begin
                            err_d  = 1'b1;
                            ferr_d = AW'(idx_q);
                        end
                    end
                    idx_d = idx_q + CW'(1);
                    if (stop_q && mismatch) begin
                        ret_d   = cnt_d;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any run in flight
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ret_q   <= '0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ferr_q  <= '0;
            dut_a_q <= '0;
            dut_b_q <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            ferr_q  <= ferr_d;
            dut_a_q <= dut_a_d;
            dut_b_q <= dut_b_d;
            exp_q   <= exp_d;
        end
    end

endmodule

// File: tb/tb_vec_check_seq.sv
// Bench for vec_check_seq: ROM + DUT emulation, table cases, random runs vs. a run-level model.
module tb_vec_check_seq;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 20;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int KEY_W  = 256;
    localparam int TMO    = 16;
    localparam logic [KEY_W-1:0] KEY     = {4{64'h0123_4567_89ab_cdef}};
    localparam logic [KEY_W-1:0] KEY_BAD = KEY ^ 256'h1;

    logic              ap_clk, ap_rst_n, ap_start;
    logic              ap_done, ap_ready, ap_idle;
    logic [CW-1:0]     ap_return, num_vec;
    logic              stop_on_err;
    logic [KEY_W-1:0]  working_key;
    logic [AW-1:0]     rom_addr;
    logic              rom_ce;
    logic [DATA_W-1:0] a_q, b_q, z_q;
    logic              dut_start, dut_ready, dut_done;
    logic [DATA_W-1:0] dut_a, dut_b, dut_result;
    logic [AW-1:0]     first_err_idx;
    logic              err_seen, tmo_seen;

    vec_check_seq #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .KEY_W(KEY_W), .KEY_VALUE(KEY), .TMO_CYC(TMO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_return(ap_return), .num_vec(num_vec),
        .stop_on_err(stop_on_err), .working_key(working_key), .rom_addr(rom_addr),
        .rom_ce(rom_ce), .a_q(a_q), .b_q(b_q), .z_q(z_q), .dut_start(dut_start),
        .dut_ready(dut_ready), .dut_a(dut_a), .dut_b(dut_b), .dut_done(dut_done),
        .dut_result(dut_result), .first_err_idx(first_err_idx), .err_seen(err_seen),
        .tmo_seen(tmo_seen)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // vector ROM contents and per-vector DUT behaviour for the current run
    logic [DATA_W-1:0] a_rom [32];
    logic [DATA_W-1:0] b_rom [32];
    logic [DATA_W-1:0] z_rom [32];
    bit cor [32];
    bit wh  [32];
    int lat [32];
    int rd  [32];

    // emulator state
    bit rom_pend;
    int rom_pa;
    bit busy;
    int wcnt, st_cnt, issued, cur;

    typedef struct {
        int nv; bit stop; bit badkey; logic [19:0] cmask; int whi; int flat;
        int e_ret; int e_err; int e_tmo; int e_first; int e_iss;
    } tv_t;
    tv_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // one negedge worth of ROM and DUT behaviour
    task automatic env_step();
        if (rom_pend) begin
            a_q = a_rom[rom_pa]; b_q = b_rom[rom_pa]; z_q = z_rom[rom_pa];
        end else begin
            a_q = {$urandom, $urandom}; b_q = {$urandom, $urandom}; z_q = {$urandom, $urandom};
        end
        rom_pend = rom_ce;
        rom_pa   = int'(rom_addr) & 31;
        if (rom_ce) chk("rom_addr", 64'(rom_addr), 64'(issued));
        dut_ready  = 1'b0;
        dut_done   = 1'b0;
        dut_result = {$urandom, $urandom};
        if (busy) begin
            if (wcnt == 0) begin
                dut_done   = 1'b1;
                dut_result = (dut_a + dut_b) ^ DATA_W'(cor[cur]);
                busy       = 1'b0;
            end else wcnt--;
        end
        if (dut_start) begin
            if (st_cnt >= rd[issued & 31]) begin
                dut_ready = 1'b1;
                st_cnt    = 0;
                cur       = issued & 31;
                chk("operand_a", dut_a, a_rom[cur]);
                chk("operand_b", dut_b, b_rom[cur]);
                busy = !wh[cur];
                wcnt = lat[cur];
                issued++;
            end else st_cnt++;
        end else st_cnt = 0;
    endtask

    // run-level reference: outcome of each vector decided straight from the rules
    task automatic model(input int nv, input bit stop, input bit badkey,
                         output int ret, output int err, output int tmo,
                         output int first, output int iss, output int cyc);
        int n;
        bit stopped, to, mis;
        n = (nv > DEPTH) ? DEPTH : nv;
        ret = 0; err = 0; tmo = 0; first = 0; iss = 0; cyc = 0; stopped = 0;
        for (int i = 0; i < n; i++) begin
            iss++;
            to  = wh[i] || (lat[i] >= TMO);
            mis = to || (badkey ? !cor[i] : cor[i]);
            cyc += 3 + rd[i] + (to ? TMO : lat[i] + 1);
            if (to) tmo = 1;
            if (mis) begin
                if (!err) first = i;
                err = 1;
                if (ret < (1 << CW) - 1) ret++;
                if (stop) begin stopped = 1; break; end
            end
        end
        cyc += (stopped ? 0 : 1) + 1;
    endtask

    task automatic do_run(input int nv, input bit stop, input bit badkey, input int hold,
                          output int o_ret, output int o_err, output int o_tmo,
                          output int o_first, output int o_iss, output int o_cyc);
        bit ok;
        @(negedge ap_clk);
        working_key = badkey ? KEY_BAD : KEY;
        num_vec     = CW'(nv);
        stop_on_err = stop;
        ap_start    = 1'b1;
        issued = 0; busy = 0; st_cnt = 0;
        env_step();
        ok = 0; o_cyc = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge ap_clk);
            if (c >= hold) ap_start = 1'b0;
            if (c == 2) begin
                num_vec     = CW'($urandom);
                stop_on_err = 1'($urandom);
            end
            env_step();
            if (c == 1) chk("ap_idle_busy", 64'(ap_idle), 64'd0);
            if (ap_done) begin ok = 1; o_cyc = c; break; end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
        o_ret = int'(ap_return); o_err = int'(err_seen); o_tmo = int'(tmo_seen);
        o_first = int'(first_err_idx); o_iss = issued;
        chk("ap_ready", 64'(ap_ready), 64'(ok));
        @(negedge ap_clk);
        env_step();
        chk("done_one_cycle", 64'(ap_done), 64'd0);
        chk("ap_idle_after", 64'(ap_idle), 64'd1);
        chk("ret_hold", 64'(ap_return), 64'(o_ret));
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_done"}, 64'(ap_done), 64'd0);
        chk({tag, "_ready"}, 64'(ap_ready), 64'd0);
        chk({tag, "_idle"}, 64'(ap_idle), 64'd1);
        chk({tag, "_start"}, 64'(dut_start), 64'd0);
        chk({tag, "_rom_ce"}, 64'(rom_ce), 64'd0);
        chk({tag, "_ret"}, 64'(ap_return), 64'd0);
        chk({tag, "_flags"}, {62'd0, err_seen, tmo_seen}, 64'd0);
        chk({tag, "_ferr"}, 64'(first_err_idx), 64'd0);
        chk({tag, "_dut_a"}, dut_a, 64'd0);
        chk({tag, "_dut_b"}, dut_b, 64'd0);
    endtask

    initial begin
        int r_ret, r_err, r_tmo, r_first, r_iss, r_cyc;
        int m_ret, m_err, m_tmo, m_first, m_iss, m_cyc;
        int nv, hold, dcnt;
        bit stp, bk;

        for (int i = 0; i < 32; i++) begin
            a_rom[i] = {$urandom, $urandom};
            b_rom[i] = {$urandom, $urandom};
            z_rom[i] = a_rom[i] + b_rom[i];
            cor[i] = 0; wh[i] = 0; lat[i] = 0; rd[i] = 0;
        end
        rom_pend = 0; rom_pa = 0; busy = 0; wcnt = 0; st_cnt = 0; issued = 0; cur = 0;
        ap_rst_n = 1'b0; ap_start = 1'b0; num_vec = '0; stop_on_err = 1'b0;
        working_key = KEY; dut_ready = 1'b0; dut_done = 1'b0;
        a_q = '0; b_q = '0; z_q = '0; dut_result = '0;
        repeat (3) @(negedge ap_clk);
        check_zero_state("reset");
        ap_rst_n = 1'b1;

        // table: {num_vec, stop, badkey, corrupt mask, withheld idx, fixed latency, expected ...}
        tbl[0] = '{20, 0, 0, 20'h00000, -1, -1,  0, 0, 0, 0, 20};
        tbl[1] = '{20, 0, 0, 20'h20008, -1, -1,  2, 1, 0, 3, 20};
        tbl[2] = '{20, 1, 0, 20'h20008, -1, -1,  1, 1, 0, 3,  4};
        tbl[3] = '{20, 0, 0, 20'h00000,  5, -1,  1, 1, 1, 5, 20};
        tbl[4] = '{ 3, 0, 0, 20'h00000, -1, 15,  0, 0, 0, 0,  3};
        tbl[5] = '{20, 0, 1, 20'h00000, -1, -1, 20, 1, 0, 0, 20};
        tbl[6] = '{31, 0, 0, 20'h00000, -1, -1,  0, 0, 0, 0, 20};
        tbl[7] = '{ 0, 0, 0, 20'h00000, -1, -1,  0, 0, 0, 0,  0};

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) begin
                cor[i] = (i < 20) ? tbl[t].cmask[i] : 1'b0;
                wh[i]  = (i == tbl[t].whi);
                lat[i] = (tbl[t].flat >= 0) ? tbl[t].flat : int'($urandom_range(0, 4));
                rd[i]  = int'($urandom_range(0, 2));
            end
            hold = (tbl[t].nv == 0) ? 1 : int'($urandom_range(1, 3));
            do_run(tbl[t].nv, tbl[t].stop, tbl[t].badkey, hold,
                   r_ret, r_err, r_tmo, r_first, r_iss, r_cyc);
            model(tbl[t].nv, tbl[t].stop, tbl[t].badkey, m_ret, m_err, m_tmo, m_first, m_iss, m_cyc);
            chk($sformatf("tbl%0d_ret", t),    64'(r_ret),   64'(tbl[t].e_ret));
            chk($sformatf("tbl%0d_err", t),    64'(r_err),   64'(tbl[t].e_err));
            chk($sformatf("tbl%0d_tmo", t),    64'(r_tmo),   64'(tbl[t].e_tmo));
            chk($sformatf("tbl%0d_first", t),  64'(r_first), 64'(tbl[t].e_first));
            chk($sformatf("tbl%0d_issued", t), 64'(r_iss),   64'(tbl[t].e_iss));
            chk($sformatf("tbl%0d_cycles", t), 64'(r_cyc),   64'(m_cyc));
        end

        // empty run: FETCH then FIN
        do_run(0, 0, 0, 1, r_ret, r_err, r_tmo, r_first, r_iss, r_cyc);
        chk("n0_latency", 64'(r_cyc), 64'd2);

        // single vector with zero DUT latency: four cycles of overhead plus FETCH/FIN
        for (int i = 0; i < 32; i++) begin cor[i] = 0; wh[i] = 0; lat[i] = 0; rd[i] = 0; end
        do_run(1, 0, 0, 1, r_ret, r_err, r_tmo, r_first, r_iss, r_cyc);
        chk("one_vec_latency", 64'(r_cyc), 64'd6);

        // randomized runs against the model
        for (int t = 0; t < 30; t++) begin
            nv  = int'($urandom_range(0, 31));
            stp = 1'($urandom);
            bk  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 32; i++) begin
                cor[i] = ($urandom_range(0, 5) == 0);
                wh[i]  = ($urandom_range(0, 14) == 0);
                lat[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 15))
                                                     : int'($urandom_range(0, 4));
                rd[i]  = int'($urandom_range(0, 2));
            end
            hold = (nv == 0) ? 1 : int'($urandom_range(1, 3));
            do_run(nv, stp, bk, hold, r_ret, r_err, r_tmo, r_first, r_iss, r_cyc);
            model(nv, stp, bk, m_ret, m_err, m_tmo, m_first, m_iss, m_cyc);
            chk($sformatf("rnd%0d_ret", t),    64'(r_ret),   64'(m_ret));
            chk($sformatf("rnd%0d_err", t),    64'(r_err),   64'(m_err));
            chk($sformatf("rnd%0d_tmo", t),    64'(r_tmo),   64'(m_tmo));
            chk($sformatf("rnd%0d_first", t),  64'(r_first), 64'(m_first));
            chk($sformatf("rnd%0d_issued", t), 64'(r_iss),   64'(m_iss));
            chk($sformatf("rnd%0d_cycles", t), 64'(r_cyc),   64'(m_cyc));
        end

        // leave a nonzero result behind, then reset in the middle of a WAIT
        for (int i = 0; i < 32; i++) begin cor[i] = 0; wh[i] = 0; lat[i] = 10; rd[i] = 0; end
        do_run(20, 0, 1, 1, r_ret, r_err, r_tmo, r_first, r_iss, r_cyc);
        chk("pre_reset_ret", 64'(r_ret), 64'd20);
        @(negedge ap_clk);
        working_key = KEY; num_vec = CW'(20); stop_on_err = 1'b0; ap_start = 1'b1;
        issued = 0; busy = 0; st_cnt = 0;
        env_step();
        for (int c = 1; c <= 8; c++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            env_step();
        end
        chk("pre_reset_in_wait", {62'd0, dut_start, rom_ce}, 64'd0);
        ap_rst_n = 1'b0;
        #1;
        busy = 0; rom_pend = 0; issued = 0; st_cnt = 0;
        dut_ready = 1'b0; dut_done = 1'b0;
        check_zero_state("midreset");
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ap_clk);
            env_step();
            if (ap_done) dcnt++;
        end
        chk("no_done_after_reset", 64'(dcnt), 64'd0);
        chk("idle_after_reset", 64'(ap_idle), 64'd1);

        // fresh run after release
        for (int i = 0; i < 32; i++) begin
            cor[i] = (i == 2); wh[i] = 0; lat[i] = int'($urandom_range(0, 4)); rd[i] = 0;
        end
        do_run(5, 0, 0, 1, r_ret, r_err, r_tmo, r_first, r_iss, r_cyc);
        chk("fresh_ret", 64'(r_ret), 64'd1);
        chk("fresh_first", 64'(r_first), 64'd2);
        chk("fresh_issued", 64'(r_iss), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
